// File: rtl/scan_display_driver.sv
// Six-digit multiplexed seven-segment driver for packed-BCD HH:MM:SS with
// ghost blanking, hour leading-zero suppression, adjust blink and colon DPs.
// Optional build macro: DISP_COLON_BLINK_EN (colons flash with the 1 Hz input).
module scan_display_driver #(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic       AdjHrKey,
  input  logic       AdjMinKey,
  input  logic       _1Hz,
  output logic [6:0] Seg,
  output logic       DP,
  output logic [5:0] Dig
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [5:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

  if (DIV < BLANK_CYC + 2) begin : g_bad_div
    $error("scan_display_driver: CLK_HZ/SCAN_HZ must be at least BLANK_CYC+2");
  end

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       sh_hr, sh_min, sh_sec;
  logic             sync1, blk;
  logic             tick;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      cnt    <= '0;
      idx    <= 3'd0;
      sh_hr  <= 8'h00;
      sh_min <= 8'h00;
      sh_sec <= 8'h00;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        // Shadow only at the frame boundary so a frame never mixes two times.
        if (idx == 3'd5) begin
          sh_hr  <= Hour;
          sh_min <= Minute;
          sh_sec <= Second;
        end
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      sync1 <= 1'b0;
      blk   <= 1'b0;
    end else begin
      sync1 <= _1Hz;
      blk   <= sync1;
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  logic [3:0] nib;
  logic [6:0] seg_act;
  logic       dp_act;
  logic [5:0] dig_act;
  logic       seg_kill;

  always_comb begin
    nib = 4'h0;
    case (idx)
      3'd0:    nib = sh_sec[3:0];
      3'd1:    nib = sh_sec[7:4];
      3'd2:    nib = sh_min[3:0];
      3'd3:    nib = sh_min[7:4];
      3'd4:    nib = sh_hr[3:0];
      3'd5:    nib = sh_hr[7:4];
      default: nib = 4'h0;
    endcase

    seg_kill = 1'b0;
    if (idx == 3'd5 && sh_hr[7:4] == 4'h0) seg_kill = 1'b1;
    if (AdjMinKey && !blk && (idx == 3'd2 || idx == 3'd3)) seg_kill = 1'b1;
    if (AdjHrKey && !blk && (idx == 3'd4 || idx == 3'd5)) seg_kill = 1'b1;

    seg_act = seg_kill ? 7'h00 : decode(nib);
    dig_act = 6'b000001 << idx;
`ifdef DISP_COLON_BLINK_EN
    dp_act  = (idx == 3'd2 || idx == 3'd4) && blk;
`else
    dp_act  = (idx == 3'd2 || idx == 3'd4);
`endif

    // Ghost blanking: everything dark at the start of each slot.
    if (cnt < BLANK_END) begin
      seg_act = 7'h00;
      dig_act = 6'h00;
      dp_act  = 1'b0;
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      Seg <= SEG_INV;
      DP  <= DP_INV;
      Dig <= DIG_INV;
    end else begin
      Seg <= seg_act ^ SEG_INV;
      DP  <= dp_act ^ DP_INV;
      Dig <= dig_act ^ DIG_INV;
    end
  end

endmodule

// File: tb/tb_scan_display_driver.sv
// Bench for scan_display_driver: directed scenarios plus random inputs, every
// output cycle checked against a slot/frame arithmetic model via a queue.
module tb_scan_display_driver;

  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 6 * DIV;
  localparam int MAXK  = 8192;

  logic       clk = 1'b0;
  logic       n_cr = 1'b1;
  logic [7:0] hour = 8'h00, minute = 8'h00, second = 8'h00;
  logic       adj_hr = 1'b0, adj_min = 1'b0, one_hz = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig;

  scan_display_driver #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(BLANK),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .CP(clk), .nCR(n_cr), .Hour(hour), .Minute(minute), .Second(second),
    .AdjHrKey(adj_hr), .AdjMinKey(adj_min), ._1Hz(one_hz),
    .Seg(seg), .DP(dp), .Dig(dig)
  );

  always #5 clk = ~clk;

  // Expected {Dig, Seg, DP} per clock edge since reset release.
  logic [13:0] exp_q[$];
  // Input values seen just before edge k: {1Hz, AdjHr, AdjMin, Hour, Minute, Second}.
  logic [26:0] hist [0:MAXK-1];
  int k = 0;
  int n_check = 0;
  int n_err = 0;
  logic [13:0] mon_e;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  // Output after edge kk: slot position, digit and frame follow from kk alone;
  // time shown is what was on the inputs at the last frame-boundary edge.
  function automatic logic [13:0] model(input int kk);
    int c, slot, d, f;
    logic [23:0] sh;
    logic [7:0] pair;
    logic [3:0] nib;
    logic b, ahr, amin, p;
    logic [6:0] s;
    logic [5:0] en;
    c    = (kk - 1) % DIV;
    slot = (kk - 1) / DIV;
    d    = slot % 6;
    f    = slot / 6;
    sh   = (f == 0) ? 24'h0 : hist[f * FRAME][23:0];
    b    = (kk >= 3) ? hist[kk - 2][26] : 1'b0;
    ahr  = hist[kk][25];
    amin = hist[kk][24];
    if (c < BLANK) return {6'h3F, 7'h7F, 1'b1};
    pair = (d / 2 == 0) ? sh[7:0] : (d / 2 == 1) ? sh[15:8] : sh[23:16];
    nib  = (d % 2 == 0) ? pair[3:0] : pair[7:4];
    s    = glyph(nib);
    if (d == 5 && nib == 4'h0) s = 7'h00;
    if (!b && amin && (d == 2 || d == 3)) s = 7'h00;
    if (!b && ahr && (d == 4 || d == 5)) s = 7'h00;
    p = (d == 2 || d == 4);
`ifdef DISP_COLON_BLINK_EN
    p = p & b;
`endif
    en = 6'b000001 << d;
    return {~en, ~s, ~p};
  endfunction

  // Stimulus side of the scoreboard: record inputs, push the expectation.
  initial forever begin
    @(posedge clk);
    if (!n_cr) k = 0;
    else begin
      k++;
      if (k < MAXK) begin
        hist[k] = {one_hz, adj_hr, adj_min, hour, minute, second};
        exp_q.push_back(model(k));
      end
    end
  end

  // Monitor: compare on the falling edge, away from the launch edge.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_check++;
      if ({dig, seg, dp} !== mon_e) begin
        n_err++;
        $display("FAIL out k=%0d got dig=%h seg=%h dp=%b exp dig=%h seg=%h dp=%b",
                 k, dig, seg, dp, mon_e[13:8], mon_e[7:1], mon_e[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_check++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h exp %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    n_cr = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_dig", {26'd0, dig}, 32'h3F);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    tick(2);
    n_cr = 1'b1;
  endtask

  task automatic wait_digit(input int want);
    int guard;
    guard = 0;
    while ((((k - 1) / DIV) % 6) != want && guard < 200) begin
      tick(1);
      guard++;
    end
    if (guard >= 200) begin
      n_check++;
      n_err++;
      $display("FAIL wait_digit got timeout exp digit %0d", want);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    int hz_left;
    #3;
    n_cr = 1'b0;
    #1;
    chk("por_dig", {26'd0, dig}, 32'h3F);
    chk("por_seg", {25'd0, seg}, 32'h7F);
    chk("por_dp", {31'd0, dp}, 32'h1);
    tick(2);
    n_cr = 1'b1;

    hour = 8'h12; minute = 8'h34; second = 8'h56;
    tick(130);
    hour = 8'h09;
    tick(130);
    adj_min = 1'b1; one_hz = 1'b0;
    tick(70);
    one_hz = 1'b1;
    tick(70);
    adj_hr = 1'b1; one_hz = 1'b0;
    tick(70);
    adj_min = 1'b0; adj_hr = 1'b0;
    second = 8'h5A;
    tick(70);
    second = 8'h56; minute = 8'h34;
    tick(70);
    wait_digit(1);
    minute = 8'h35;
    tick(130);

    mid_reset();
    tick(130);
    mid_reset();

    hz_left = 25;
    for (int i = 0; i < 1800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        hour   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd($urandom_range(0, 23));
        minute = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd($urandom_range(0, 59));
        second = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd($urandom_range(0, 59));
      end
      if ($urandom_range(0, 99) == 0) adj_hr = ~adj_hr;
      if ($urandom_range(0, 99) == 0) adj_min = ~adj_min;
      hz_left--;
      if (hz_left <= 0) begin
        one_hz = ~one_hz;
        hz_left = $urandom_range(1, 80);
      end
      tick(1);
    end

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk("coverage", {31'd0, n_check > 2000}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_check, n_err);
    $finish;
  end

endmodule
